// File: rtl/block_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : block_pkg                                                  |
// | Description : Shared block type and assembler state encoding.            |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package block_pkg;

    localparam int BLOCK_BYTES = 16;

    typedef logic [BLOCK_BYTES-1:0][7:0] block_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } asm_state_t;

endpackage
`default_nettype wire

// File: rtl/assemble_block.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : assemble_block                                             |
// | Description : Packs NUM_BYTES serial bytes into one block with a         |
// |               valid/ready hand-off to the block-wide datapath.           |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module assemble_block
    import block_pkg::*;
#(
    parameter int NUM_BYTES = BLOCK_BYTES
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      start_in,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid_in,
    output logic                      request_out,
    output logic [NUM_BYTES-1:0][7:0] block_out,
    output logic                      block_valid_out,
    input  logic                      block_ready_in,
    output logic                      busy_out,
    output logic                      overrun_out
);

    localparam int CNT_W = $clog2(NUM_BYTES) + 1;
    localparam int IDX_W = $clog2(NUM_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    asm_state_t                r_state;
    asm_state_t                w_next;
    logic [CNT_W-1:0]          r_count;
    logic [NUM_BYTES-1:0][7:0] r_block;
    logic                      r_overrun;

    logic w_start_accept;
    logic w_accept_byte;
    logic w_last_byte;

    // A start is honoured from IDLE, or from HOLD only together with ready.
    assign w_start_accept = start_in &&
                            ((r_state == ST_IDLE) ||
                             ((r_state == ST_HOLD) && block_ready_in));
    assign w_accept_byte  = (r_state == ST_COLLECT) && byte_valid_in;
    assign w_last_byte    = w_accept_byte && (r_count == LAST_IDX);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_in) begin
                    w_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (w_last_byte) begin
                    w_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (block_ready_in) begin
                    w_next = start_in ? ST_COLLECT : ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_block   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_accept) begin
                r_count   <= '0;
                r_block   <= '0;
                r_overrun <= 1'b0;
            end else begin
                if (w_accept_byte) begin
                    r_block[r_count[IDX_W-1:0]] <= byte_in;
                    r_count <= w_last_byte ? '0 : r_count + CNT_W'(1);
                end
                if (byte_valid_in && (r_state != ST_COLLECT)) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign request_out     = (r_state == ST_COLLECT);
    assign block_valid_out = (r_state == ST_HOLD);
    assign busy_out        = (r_state != ST_IDLE);
    assign block_out       = r_block;
    assign overrun_out     = r_overrun;

endmodule
`default_nettype wire
